// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the Light Cycles round sequencer.
//   phase_t      : round state encoding driven out on the phase port
//   bcd_t        : one BCD digit (0..9)
//   MAX_MIN_BCD  : elapsed-minutes ceiling, two BCD digits
//   bcd2_inc     : increments a two-digit BCD value (caller handles the top)
// ---------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      COUNTDOWN = 3'd1,
      PLAY      = 3'd2,
      PAUSED    = 3'd3,
      OVER      = 3'd4
   } phase_t;

   typedef logic [3:0] bcd_t;

   localparam logic [7:0] MAX_MIN_BCD = 8'h99;
   localparam logic [7:0] MAX_SEC_BCD = 8'h59;

   // Low digit rolls 9 -> 0 and carries into the high digit. Callers never
   // pass 8'h99, so the high digit never overflows here.
   function automatic logic [7:0] bcd2_inc(input logic [7:0] value);
      logic [7:0] result;
      if (value[3:0] == 4'd9) begin
         result = {value[7:4] + 4'd1, 4'd0};
      end else begin
         result = {value[7:4], value[3:0] + 4'd1};
      end
      return result;
   endfunction

endpackage

// File: rtl/game_phase_ctrl_if.sv
// ---------------------------------------------------------------------------
// game_phase_ctrl_if
// Bundles the tick/button/crash inputs and the step/phase/display outputs
// of the round sequencer.
//   master : side that produces ticks and buttons, consumes the outputs
//   slave  : the sequencer itself
// ---------------------------------------------------------------------------
interface game_phase_ctrl_if;
   import game_pkg::*;

   logic          game_tick;
   logic          sec_tick;
   logic          start;
   logic          pause;
   logic          crash;
   logic          step;
   phase_t        phase;
   bcd_t          cd_digit;
   logic [7:0]    min_bcd;
   logic [7:0]    sec_bcd;
   logic          round_clr;

   modport master (
      output game_tick, sec_tick, start, pause, crash,
      input  step, phase, cd_digit, min_bcd, sec_bcd, round_clr
   );

   modport slave (
      input  game_tick, sec_tick, start, pause, crash,
      output step, phase, cd_digit, min_bcd, sec_bcd, round_clr
   );

endinterface

// File: rtl/bcd_mmss_counter.sv
// ---------------------------------------------------------------------------
// bcd_mmss_counter
// Elapsed-time counter in mm:ss BCD, saturating at 99:59.
//   clk, rst  : clock, asynchronous active-high reset
//   inc       : count one second
//   clr       : return to 00:00 (wins over inc)
//   freeze    : ignore inc
//   min_bcd   : minutes, two BCD digits
//   sec_bcd   : seconds, two BCD digits
// ---------------------------------------------------------------------------
module bcd_mmss_counter
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic       clr,
   input  logic       freeze,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd
);

   logic [7:0] min_q;
   logic [7:0] sec_q;

   // Seconds roll 59 -> 00 with a minute carry; at 99:59 the count holds
   // rather than wrapping so a long round never shows a bogus short time.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         min_q <= '0;
         sec_q <= '0;
      end else if (clr) begin
         min_q <= '0;
         sec_q <= '0;
      end else if (inc && !freeze) begin
         if (min_q == MAX_MIN_BCD && sec_q == MAX_SEC_BCD) begin
            min_q <= min_q;
            sec_q <= sec_q;
         end else if (sec_q == MAX_SEC_BCD) begin
            sec_q <= '0;
            min_q <= bcd2_inc(min_q);
         end else begin
            sec_q <= bcd2_inc(sec_q);
         end
      end
   end

   assign min_bcd = min_q;
   assign sec_bcd = sec_q;

endmodule

// File: rtl/game_phase_ctrl.sv
// ---------------------------------------------------------------------------
// game_phase_ctrl
// Round sequencer for Light Cycles: IDLE -> COUNTDOWN -> PLAY <-> PAUSED
// -> OVER. Turns game ticks into gated step pulses with a step divider that
// speeds up over time, and produces countdown / elapsed-time BCD digits.
//   clk, rst   : 100 MHz clock, asynchronous active-high reset
//   bus.slave  : game_tick, sec_tick, start, pause, crash in;
//                step, phase, cd_digit, min_bcd, sec_bcd, round_clr out
// ---------------------------------------------------------------------------
module game_phase_ctrl
   import game_pkg::*;
#(
   parameter int COUNTDOWN_SEC = 3,
   parameter int STEP_DIV_INIT = 2,
   parameter int SPEEDUP_SEC   = 30
) (
   input  logic                clk,
   input  logic                rst,
   game_phase_ctrl_if.slave    bus
);

   localparam int              SPD_W    = $clog2(SPEEDUP_SEC + 1);
   localparam logic [SPD_W-1:0] SPD_LAST = SPD_W'(SPEEDUP_SEC - 1);
   localparam logic [3:0]      DIV_INIT = 4'(STEP_DIV_INIT);
   localparam bcd_t            CD_INIT  = bcd_t'(COUNTDOWN_SEC);

   phase_t           phase_q;
   logic             step_q;
   logic             round_clr_q;
   bcd_t             cd_q;
   logic [3:0]       step_div;
   logic [3:0]       tick_cnt;
   logic [SPD_W-1:0] speed_cnt;
   logic             start_q;
   logic             pause_q;

   logic             start_edge;
   logic             pause_edge;
   logic             new_round;
   logic             elapsed_inc;
   logic             elapsed_freeze;

   assign start_edge = bus.start & ~start_q;
   assign pause_edge = bus.pause & ~pause_q;

   // A round (re)starts only from IDLE or OVER; start edges elsewhere are
   // dropped. The elapsed counter clears in the same cycle as round_clr.
   assign new_round      = start_edge && (phase_q == IDLE || phase_q == OVER);
   assign elapsed_inc    = (phase_q == PLAY) && bus.sec_tick && !bus.crash;
   assign elapsed_freeze = (phase_q != PLAY);

   // Round state machine. step and round_clr default low every cycle so
   // they are single-cycle strobes. A crash in PLAY ends the round before
   // any tick or pause is looked at. The tick compare uses >= so a step_div
   // decrement that lands below the current tick_cnt still fires at once
   // instead of letting tick_cnt run on past the divider. step is also
   // suppressed when it was high last cycle so it never lasts two cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q     <= IDLE;
         step_q      <= 1'b0;
         round_clr_q <= 1'b0;
         cd_q        <= '0;
         step_div    <= DIV_INIT;
         tick_cnt    <= '0;
         speed_cnt   <= '0;
         start_q     <= 1'b0;
         pause_q     <= 1'b0;
      end else begin
         start_q     <= bus.start;
         pause_q     <= bus.pause;
         step_q      <= 1'b0;
         round_clr_q <= 1'b0;
         case (phase_q)
            IDLE, OVER: begin
               if (start_edge) begin
                  phase_q     <= COUNTDOWN;
                  round_clr_q <= 1'b1;
                  cd_q        <= CD_INIT;
                  step_div    <= DIV_INIT;
                  tick_cnt    <= '0;
                  speed_cnt   <= '0;
               end
            end
            COUNTDOWN: begin
               if (bus.sec_tick) begin
                  if (cd_q <= 4'd1) begin
                     cd_q    <= '0;
                     phase_q <= PLAY;
                  end else begin
                     cd_q <= cd_q - 4'd1;
                  end
               end
            end
            PLAY: begin
               if (bus.crash) begin
                  phase_q <= OVER;
               end else begin
                  if (bus.game_tick) begin
                     if (tick_cnt >= step_div - 4'd1) begin
                        tick_cnt <= '0;
                        step_q   <= ~step_q;
                     end else begin
                        tick_cnt <= tick_cnt + 4'd1;
                     end
                  end
                  if (bus.sec_tick) begin
                     if (speed_cnt == SPD_LAST) begin
                        speed_cnt <= '0;
                        if (step_div > 4'd1) begin
                           step_div <= step_div - 4'd1;
                        end
                     end else begin
                        speed_cnt <= speed_cnt + 1'b1;
                     end
                  end
                  if (pause_edge) begin
                     phase_q <= PAUSED;
                  end
               end
            end
            PAUSED: begin
               if (bus.crash) begin
                  phase_q <= OVER;
               end else if (pause_edge) begin
                  phase_q <= PLAY;
               end
            end
            default: begin
               phase_q <= IDLE;
            end
         endcase
      end
   end

   bcd_mmss_counter u_elapsed (
      .clk     (clk),
      .rst     (rst),
      .inc     (elapsed_inc),
      .clr     (new_round),
      .freeze  (elapsed_freeze),
      .min_bcd (bus.min_bcd),
      .sec_bcd (bus.sec_bcd)
   );

   assign bus.step      = step_q;
   assign bus.phase     = phase_q;
   assign bus.cd_digit  = cd_q;
   assign bus.round_clr = round_clr_q;

endmodule
